uart_rx_with_buf: RTL and testbench
===================================

// Module: uart_rx_with_buf
// PURPOSE
//  Receive side of the board UART link: 8N1 serial receiver with a FIFO of received bytes.
//  Sits beside the buffered UART transmitter in the processor top. rxd comes from the pin; the core
//  pops bytes with a valid/ready-style handshake. Framing errors and overruns are reported as pulses.
// PARAMETERS
//  CLK_PER_BIT  868  clk cycles per bit (100 MHz / 115200); must be >= 8
//  BUF_LOG      4    log2 of FIFO depth (default 16 entries)
// PORTS
//  clk       in   1  system clock; single clock domain
//  rstn      in   1  reset, asynchronous, active-low
//  rxd       in   1  serial input, idle high, asynchronous to clk
//  rdata     out  8  FIFO head byte; valid only while rx_valid=1
//  rx_valid  out  1  FIFO non-empty
//  rx_pop    in   1  core consumes head this cycle (ignored when rx_valid=0)
//  ferr      out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  overrun   out  1  1-cycle pulse: byte completed while FIFO full, byte discarded
// BEHAVIOUR
//  Reset: rdata=0, rx_valid=0, ferr=0, overrun=0; FIFO empty; FSM=IDLE; synchroniser flops = 1.
//  - rxd passes through a 2-FF synchroniser (rxd_s); all decisions use rxd_s only.
//  - Arming: after reset, IDLE ignores falling edges until rxd_s has been 1 for >= 1 cycle.
//  FSM (bit counter cnt, bit index idx 0..7):
//  - IDLE : rxd_s 1->0 edge -> START, cnt=0.
//  - START: at cnt=CLK_PER_BIT/2-1 resample; rxd_s=1 -> IDLE (glitch, no pulse); else -> DATA, cnt=0, idx=0.
//  - DATA : at cnt=CLK_PER_BIT-1 shift rxd_s in LSB-first (sample at bit centre), cnt=0;
//           after idx=7 sampled -> STOP.
//  - STOP : at cnt=CLK_PER_BIT-1 sample; 1 -> push request; 0 -> ferr pulse, no push. Go to IDLE;
//           IDLE must accept a new start edge in the next cycle (back-to-back frames, 1 stop bit).
//  - Line held low after a ferr: no new frame until rxd_s returns high (re-arm as after reset).
//  FIFO (first-word-fall-through, BUF_LOG-bit pointers plus count or extra wrap bit):
//  - Push appears on rdata/rx_valid exactly 1 cycle after the STOP-centre sample cycle.
//  - rx_pop with rx_valid=1 advances head; next entry visible the following cycle.
//  - Full + push, no pop -> overrun pulse, byte dropped, FIFO unchanged.
//  - Full + push + pop same cycle -> both happen, no overrun, count unchanged.
//  - Empty + pop -> ignored. Empty + push + pop -> pop ignored, byte stored.
//  - Pointers wrap modulo 2**BUF_LOG; full/empty distinction must be exact at depth boundary.
//  - rstn low mid-frame: FSM, partial byte and FIFO all cleared immediately; frame lost, no pulses.
//  Arithmetic: cnt width $clog2(CLK_PER_BIT); no other counters exceed their range.
// STRUCTURE
//  - Shared package/header: CLK_PER_BIT default for 115200 baud (also used by the transmitter),
//    FSM state encoding localparams (IDLE/START/DATA/STOP).
//  - One sub-module: uart_rx (synchroniser + FSM, outputs byte + 1-cycle done/ferr strobes);
//    FIFO and overrun logic live in this top module.
// TESTING (bench uses CLK_PER_BIT=16, BUF_LOG=2)
//  - Send 0xA5 8N1 -> rx_valid rises 1 cycle after stop centre, rdata=0xA5; pop -> rx_valid=0.
//  - Send 0x00,0xFF,0x3C back-to-back, no idle gap -> popped in order 0x00,0xFF,0x3C, no pulses.
//  - 2-cycle low glitch on idle rxd -> no byte, no ferr; then 0x55 received correctly.
//  - Frame 0x81 with stop bit 0 -> ferr pulse 1 cycle, rx_valid stays 0.
//  - Send 5 bytes 0x10..0x14, no pops -> 4 stored, overrun pulse on 0x14; pops yield 0x10..0x13.
//  - Full FIFO, pop in push cycle of 0x20 -> no overrun, final order ends with 0x20.
//  - Assert rstn mid-DATA of 0x77 -> outputs 0 immediately; next 0x12 after release received.

Source files
------------

// File: rtl/uart_rx_with_buf_pkg.sv
// Shared definitions for the board UART link.
// Holds the default bit period for 115200 baud at 100 MHz, which the transmitter
// also uses. It also holds the default receive buffer depth and the receiver FSM
// state encoding.
package uart_rx_with_buf_pkg;

  localparam int UART_CLK_PER_BIT = 868;
  localparam int RX_BUF_LOG       = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    RX_IDLE  = ST_IDLE,
    RX_START = ST_START,
    RX_DATA  = ST_DATA,
    RX_STOP  = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_with_buf_rx.sv
// 8N1 serial receiver: a 2-FF synchroniser followed by the framing FSM.
// Ports:
//   clk, rstn  - clock and asynchronous active-low reset
//   rxd        - raw serial input (idle high, asynchronous to clk)
//   rx_byte    - assembled byte; complete while done is high
//   done       - strobe in the stop-centre sample cycle when the stop bit is 1
//   ferr       - strobe in the stop-centre sample cycle when the stop bit is 0
module uart_rx
  import uart_rx_with_buf_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       ferr
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  logic          meta_r, sync_r, prev_r;
  logic          rxd_s;
  rx_state_t     state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [2:0]    idx_r, idx_n;
  logic [7:0]    data_r, data_n;

  assign rxd_s   = sync_r;
  assign rx_byte = data_r;

  // Synchroniser and previous-sample flop.
  // prev_r resets to 0, so no start edge is seen until rxd_s has been high for a
  // cycle. That covers arming after reset and re-arming after a line held low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b0;
    end else begin
      meta_r <= rxd;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // FSM state, bit counter, bit index and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= RX_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      data_r  <= data_n;
    end
  end

  // Next-state logic and the done/ferr strobes for the stop-centre sample cycle.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    data_n  = data_r;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_n = CNT_ZERO;
        if (prev_r && !rxd_s) begin
          state_n = RX_START;
        end else begin
          state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_n = CNT_ZERO;
          idx_n = 3'd0;
          // A high line at mid start bit was a glitch; drop it silently.
          if (rxd_s) begin
            state_n = RX_IDLE;
          end else begin
            state_n = RX_DATA;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_n  = CNT_ZERO;
          data_n = {rxd_s, data_r[7:1]};
          if (idx_r == 3'd7) begin
            state_n = RX_STOP;
          end else begin
            idx_n = idx_r + 3'd1;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_n   = CNT_ZERO;
          state_n = RX_IDLE;
          if (rxd_s) begin
            done = 1'b1;
          end else begin
            ferr = 1'b1;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_n = RX_IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/uart_rx_with_buf.sv
// UART receiver with a first-word-fall-through FIFO of received bytes.
// Ports:
//   clk, rstn - clock and asynchronous active-low reset
//   rxd       - serial input from the pin
//   rdata     - FIFO head byte, valid while rx_valid is high
//   rx_valid  - FIFO non-empty
//   rx_pop    - consume the head this cycle (ignored while empty)
//   ferr      - 1-cycle pulse: stop bit was 0, byte discarded
//   overrun   - 1-cycle pulse: byte arrived while full with no pop, byte discarded
module uart_rx_with_buf
  import uart_rx_with_buf_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
  parameter int BUF_LOG     = RX_BUF_LOG
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_valid,
  input  logic       rx_pop,
  output logic       ferr,
  output logic       overrun
);

  localparam int DEPTH = 1 << BUF_LOG;
  localparam logic [BUF_LOG:0]   CNT_FULL = (BUF_LOG + 1)'(DEPTH);
  localparam logic [BUF_LOG:0]   CNT_ONE  = (BUF_LOG + 1)'(1);
  localparam logic [BUF_LOG:0]   CNT_ZERO = {(BUF_LOG + 1){1'b0}};
  localparam logic [BUF_LOG-1:0] PTR_ONE  = BUF_LOG'(1);
  localparam logic [BUF_LOG-1:0] PTR_ZERO = {BUF_LOG{1'b0}};

  logic [7:0]         rx_byte;
  logic               rx_done, rx_ferr;
  logic [7:0]         mem_r [DEPTH];
  logic [BUF_LOG-1:0] head_r, tail_r, head_n, tail_n;
  logic [BUF_LOG:0]   count_r, count_n;
  logic [7:0]         rdata_r, head_byte_n;
  logic               valid_r, ferr_r, ovr_r;
  logic               pop_ok, full, push_ok, ovr_hit;

  uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rx_byte (rx_byte),
    .done    (rx_done),
    .ferr    (rx_ferr)
  );

  assign rdata    = rdata_r;
  assign rx_valid = valid_r;
  assign ferr     = ferr_r;
  assign overrun  = ovr_r;

  // FIFO control. A pop frees a slot in the same cycle, so full + push + pop is legal.
  always_comb begin
    pop_ok  = rx_pop && valid_r;
    full    = (count_r == CNT_FULL);
    push_ok = rx_done && (!full || pop_ok);
    ovr_hit = rx_done && full && !pop_ok;
    if (pop_ok) begin
      head_n = head_r + PTR_ONE;
    end else begin
      head_n = head_r;
    end
    if (push_ok) begin
      tail_n = tail_r + PTR_ONE;
    end else begin
      tail_n = tail_r;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_n = count_r + CNT_ONE;
      2'b01:   count_n = count_r - CNT_ONE;
      default: count_n = count_r;
    endcase
    // The write slot equals the new head only when the FIFO ends up holding exactly
    // the incoming byte, so forward it straight into the registered head.
    if (push_ok && (tail_r == head_n)) begin
      head_byte_n = rx_byte;
    end else begin
      head_byte_n = mem_r[head_n];
    end
  end

  // Byte storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_ok) begin
      mem_r[tail_r] <= rx_byte;
    end
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      rdata_r <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      head_r  <= head_n;
      tail_r  <= tail_n;
      count_r <= count_n;
      rdata_r <= head_byte_n;
      valid_r <= (count_n != CNT_ZERO);
      ferr_r  <= rx_ferr;
      ovr_r   <= ovr_hit;
    end
  end

endmodule

// File: tb/tb_uart_rx_with_buf.sv
// Self-checking bench for uart_rx_with_buf, using CLK_PER_BIT=16 and BUF_LOG=2.
module tb_uart_rx_with_buf;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    int         exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_pop = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid, ferr, overrun;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int f0, o0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  uart_rx_with_buf #(.CLK_PER_BIT(CPB), .BUF_LOG(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rdata    (rdata),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .ferr     (ferr),
    .overrun  (overrun)
  );

  // Count every cycle each pulse output is high, so a pulse wider than 1 cycle counts more than once.
  always @(negedge clk) begin
    if (ferr) ferr_cnt = ferr_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, then the stop level held for stop_ticks cycles.
  task automatic send_part(input logic [7:0] b, input logic stop, input int stop_ticks);
    rxd = 1'b0;
    repeat (CPB) tick;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick;
    end
    rxd = stop;
    repeat (stop_ticks) tick;
  endtask

  task automatic send(input logic [7:0] b);
    send_part(b, 1'b1, CPB);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, 32'(rx_valid), 32'd1);
    chk({name, "_data"}, 32'(rdata), 32'(exp));
    rx_pop = 1'b1;
    tick;
    rx_pop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 8'h00, 1};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};

    // Reset state.
    repeat (3) tick;
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    repeat (5) tick;

    // 0xA5: stop centre is sampled 155 cycles after the start edge is driven, so the byte shows one cycle later.
    send_part(8'hA5, 1'b1, 10);
    chk("a5_early_valid", 32'(rx_valid), 32'd0);
    tick;
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_data", 32'(rdata), 32'hA5);
    repeat (5) tick;
    rx_pop = 1'b1;
    tick;
    rx_pop = 1'b0;
    chk("a5_popped", 32'(rx_valid), 32'd0);

    // Single-frame vectors. A stop-low frame holds the line low well past stop centre.
    for (int v = 0; v < 6; v++) begin
      f0 = ferr_cnt;
      send_part(vecs[v].data, vecs[v].stop, vecs[v].stop ? CPB : 40);
      rxd = 1'b1;
      repeat (4) tick;
      chk($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      chk($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) begin
        pop_check($sformatf("vec%0d", v), vecs[v].exp_rdata);
      end
    end

    // Back-to-back frames with no idle gap.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    repeat (3) tick;
    pop_check("b2b0", 8'h00);
    pop_check("b2b1", 8'hFF);
    pop_check("b2b2", 8'h3C);
    chk("b2b_empty", 32'(rx_valid), 32'd0);
    chk("b2b_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

    // 2-cycle glitch on an idle line, then a real frame.
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (2) tick;
    rxd = 1'b1;
    repeat (30) tick;
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    send(8'h55);
    repeat (2) tick;
    pop_check("after_glitch", 8'h55);

    // Five bytes without pops into a 4-deep FIFO.
    o0 = ovr_cnt;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    repeat (2) tick;
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_pop%0d", i), 8'h10 + 8'(i));
    chk("ovr_empty", 32'(rx_valid), 32'd0);

    // Full FIFO, pop in the same cycle that 0x20 is pushed.
    o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
    send_part(8'h20, 1'b1, 10);
    rx_pop = 1'b1;
    tick;
    rx_pop = 1'b0;
    repeat (5) tick;
    chk("fullpop_ovr", 32'(ovr_cnt - o0), 32'd0);
    pop_check("fullpop0", 8'h31);
    pop_check("fullpop1", 8'h32);
    pop_check("fullpop2", 8'h33);
    pop_check("fullpop3", 8'h20);
    chk("fullpop_empty", 32'(rx_valid), 32'd0);

    // Pop while empty is ignored. Push with pop while empty stores the byte.
    rx_pop = 1'b1;
    tick;
    rx_pop = 1'b0;
    chk("empty_pop", 32'(rx_valid), 32'd0);
    send_part(8'h6B, 1'b1, 10);
    rx_pop = 1'b1;
    tick;
    rx_pop = 1'b0;
    chk("emptypush_valid", 32'(rx_valid), 32'd1);
    chk("emptypush_data", 32'(rdata), 32'h6B);
    repeat (5) tick;
    pop_check("emptypush_pop", 8'h6B);

    // Reset in the middle of the data bits of 0x77, with one byte already stored.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send(8'h99);
    rxd = 1'b0;
    repeat (CPB) tick;
    for (int i = 0; i < 3; i++) begin
      rxd = (8'h77 >> i) & 8'h01;
      repeat (CPB) tick;
    end
    chk("midrst_pre_valid", 32'(rx_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    rxd = 1'b1;
    repeat (5) tick;
    rstn = 1'b1;
    repeat (5) tick;
    chk("postrst_valid", 32'(rx_valid), 32'd0);
    send(8'h12);
    repeat (2) tick;
    pop_check("postrst", 8'h12);
    chk("postrst_empty", 32'(rx_valid), 32'd0);
    chk("midrst_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
